bp_update_engine: RTL and testbench

Branch-predictor update engine: receives the per-branch verify/update stream (`update_valid` + `Update_Branch_S`) from the branch verify unit and turns it into writes to the BTB and PHT. It sits between the backend verify stage and the fetch-side predictor tables, absorbing bursts in a small FIFO so table-port contention never drops updates silently. It also returns the recovered GHR on mispredict and clears both tables after reset.

---
 rtl/bp_update_engine_pkg.sv | 46 ++++
 rtl/bp_update_fifo.sv | 48 ++++
 rtl/bp_update_engine.sv | 161 ++++++++++++++++
 tb/tb_bp_update_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_engine_pkg.sv
// bp_update_engine_pkg: shared types, widths and counter helpers
// for the branch-predictor update engine.
package bp_update_engine_pkg;

  localparam int BP_IDX_W = 8;
  localparam int BP_GHR_W = 8;
  localparam int BP_TAG_W = 32 - BP_IDX_W - 3;

  localparam logic [1:0] PHT_RESET = 2'b01;

  typedef enum logic [1:0] {
    BR_COND,
    BR_JUMP,
    BR_CALL,
    BR_RET
  } BranchType_E;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    BranchType_E         btype;
  } btb_entry_t;

  typedef struct packed {
    logic                PC_Vaild;
    logic                PC_Taken;
    logic                PC_MissPredict;
    logic [31:0]         Update_PC;
    logic                Update_Location;
    logic [31:0]         Update_Target;
    BranchType_E         BranchType;
    logic [1:0]          TBT_Counter;
    logic [BP_GHR_W-1:0] GHR;
    logic [BP_GHR_W-1:0] Recover_GHR;
  } Update_Branch_S;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: power-of-two ring buffer holding pending
// predictor updates; caller must not push when full or pop when empty.
module bp_update_fifo
  import bp_update_engine_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = Update_Branch_S
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bp_update_engine.sv
// bp_update_engine: turns the verify/update stream into BTB/PHT writes.
// Define BP_UPDATE_STATS_EN to add the stat_* counter ports.
module bp_update_engine
  import bp_update_engine_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int GHR_W = BP_GHR_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_valid,
  input  Update_Branch_S   upd,
  input  logic             table_ready,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic             btb_slot,
  output btb_entry_t       btb_wdata,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_idx,
  output logic [1:0]       pht_wdata,
  output logic             ghr_recover_valid,
  output logic [GHR_W-1:0] ghr_recover,
  output logic             init_done,
  output logic             upd_overflow
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispredicts,
  output logic [31:0]      stat_drops,
  output logic [31:0]      stat_stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {INIT, IDLE, WRITE} state_e;

  state_e         state;
  state_e         state_nxt;
  logic [IDX_W:0] sweep;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [CW-1:0]  count;
  Update_Branch_S head;
  logic [IDX_W-1:0] head_idx;
  logic           head_nop;
  logic           sweep_last;

  assign push       = update_valid && !full;
  assign head_idx   = head.Update_PC[IDX_W+2:3];
  assign head_nop   = !head.PC_Vaild && !head.PC_MissPredict;
  assign sweep_last = &sweep;
  // entries that touch no table need no write port
  assign pop = (state == WRITE) && (table_ready || head_nop);

  bp_update_fifo #(
    .DEPTH (DEPTH),
    .T     (Update_Branch_S)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (upd),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_nxt = state;
    btb_we    = 1'b0;
    btb_idx   = '0;
    btb_slot  = 1'b0;
    btb_wdata = '0;
    pht_we    = 1'b0;
    pht_idx   = '0;
    pht_wdata = '0;
    unique case (state)
      INIT: begin
        btb_we    = table_ready;
        pht_we    = table_ready;
        btb_idx   = sweep[IDX_W:1];
        btb_slot  = sweep[0];
        pht_idx   = sweep[IDX_W:1];
        pht_wdata = PHT_RESET;
        if (table_ready && sweep_last) state_nxt = IDLE;
      end
      IDLE: begin
        if (!empty && init_done) state_nxt = WRITE;
      end
      WRITE: begin
        btb_idx  = head_idx;
        btb_slot = head.Update_Location;
        btb_we   = head.PC_MissPredict;
        if (head.PC_Vaild) begin
          pht_we    = 1'b1;
          pht_idx   = head_idx ^ IDX_W'(head.GHR);
          pht_wdata = head.PC_Taken ? sat_inc(head.TBT_Counter)
                                    : sat_dec(head.TBT_Counter);
          btb_wdata.valid  = 1'b1;
          btb_wdata.tag    = BP_TAG_W'(head.Update_PC >> (IDX_W + 3));
          btb_wdata.target = head.Update_Target;
          btb_wdata.btype  = head.BranchType;
        end
        if (pop) state_nxt = (count != CW'(1)) ? WRITE : IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= INIT;
      sweep             <= '0;
      init_done         <= 1'b0;
      upd_overflow      <= 1'b0;
      ghr_recover_valid <= 1'b0;
      ghr_recover       <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && table_ready) begin
        sweep <= sweep + 1'b1;
        if (sweep_last) init_done <= 1'b1;
      end
      if (update_valid && full) upd_overflow <= 1'b1;
      // recovery bypasses the FIFO, so drops still restore history
      ghr_recover_valid <= update_valid && upd.PC_MissPredict;
      if (update_valid && upd.PC_MissPredict) begin
        ghr_recover <= upd.PC_Vaild
          ? GHR_W'({upd.Recover_GHR[BP_GHR_W-2:0], upd.PC_Taken})
          : GHR_W'(upd.Recover_GHR);
      end
    end
  end

`ifdef BP_UPDATE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates      <= '0;
      stat_mispredicts  <= '0;
      stat_drops        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (update_valid)
        stat_updates <= stat_updates + 32'd1;
      if (update_valid && upd.PC_MissPredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
      if (update_valid && full)
        stat_drops <= stat_drops + 32'd1;
      if (state == WRITE && !table_ready)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_engine.sv
// tb_bp_update_engine: directed and randomized checks of the
// update engine against a queue-based table-write model.
module tb_bp_update_engine;
  import bp_update_engine_pkg::*;

  localparam int IDX_W = 8;
  localparam int GHR_W = 8;
  localparam int DEPTH = 4;
  localparam int ROWS  = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             update_valid = 1'b0;
  logic             table_ready = 1'b0;
  Update_Branch_S   upd = '0;
  logic             btb_we;
  logic [IDX_W-1:0] btb_idx;
  logic             btb_slot;
  btb_entry_t       btb_wdata;
  logic             pht_we;
  logic [IDX_W-1:0] pht_idx;
  logic [1:0]       pht_wdata;
  logic             ghr_recover_valid;
  logic [GHR_W-1:0] ghr_recover;
  logic             init_done;
  logic             upd_overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] btb_log[$];
  logic [127:0] pht_log[$];
  logic [127:0] ghr_log[$];
  logic [127:0] exp_btb[$];
  logic [127:0] exp_pht[$];
  logic [127:0] exp_ghr[$];

  always #5 clk = ~clk;

  bp_update_engine #(
    .IDX_W (IDX_W),
    .GHR_W (GHR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .update_valid      (update_valid),
    .upd               (upd),
    .table_ready       (table_ready),
    .btb_we            (btb_we),
    .btb_idx           (btb_idx),
    .btb_slot          (btb_slot),
    .btb_wdata         (btb_wdata),
    .pht_we            (pht_we),
    .pht_idx           (pht_idx),
    .pht_wdata         (pht_wdata),
    .ghr_recover_valid (ghr_recover_valid),
    .ghr_recover       (ghr_recover),
    .init_done         (init_done),
    .upd_overflow      (upd_overflow)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (btb_we && table_ready)
        btb_log.push_back(128'({btb_idx, btb_slot, btb_wdata}));
      if (pht_we && table_ready)
        pht_log.push_back(128'({pht_idx, pht_wdata}));
      if (ghr_recover_valid)
        ghr_log.push_back(128'(ghr_recover));
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input Update_Branch_S u);
    update_valid = 1'b1;
    upd = u;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic clear_all();
    btb_log.delete(); pht_log.delete(); ghr_log.delete();
    exp_btb.delete(); exp_pht.delete(); exp_ghr.delete();
  endtask

  // expected table writes and history restore, from the update rules
  task automatic model(input Update_Branch_S u, input bit accepted);
    logic [31:0] idx, tg, pidx, c, nc, g;
    idx = (u.Update_PC >> 3) % ROWS;
    tg  = u.Update_PC >> (IDX_W + 3);
    if (u.PC_MissPredict) begin
      g = {24'b0, u.Recover_GHR};
      if (u.PC_Vaild) g = ((g << 1) | 32'(u.PC_Taken)) & 32'hFF;
      exp_ghr.push_back(128'(g));
    end
    if (accepted) begin
      if (u.PC_Vaild) begin
        pidx = idx ^ ({24'b0, u.GHR} % ROWS);
        c = {30'b0, u.TBT_Counter};
        if (u.PC_Taken) nc = (c == 3) ? 3 : c + 1;
        else            nc = (c == 0) ? 0 : c - 1;
        exp_pht.push_back(128'({pidx[7:0], nc[1:0]}));
        if (u.PC_MissPredict)
          exp_btb.push_back(128'({idx[7:0], u.Update_Location, 1'b1,
                                  tg[20:0], u.Update_Target, u.BranchType}));
      end else if (u.PC_MissPredict) begin
        exp_btb.push_back(128'({idx[7:0], u.Update_Location, 56'b0}));
      end
    end
  endtask

  task automatic compare(input string tag, input int skip);
    chk({tag, "_btb_cnt"}, 128'(btb_log.size() - skip), 128'(exp_btb.size()));
    chk({tag, "_pht_cnt"}, 128'(pht_log.size() - skip), 128'(exp_pht.size()));
    chk({tag, "_ghr_cnt"}, 128'(ghr_log.size()), 128'(exp_ghr.size()));
    for (int i = 0; i < exp_btb.size(); i++)
      if (i + skip < btb_log.size())
        chk({tag, "_btb"}, btb_log[i+skip], exp_btb[i]);
    for (int i = 0; i < exp_pht.size(); i++)
      if (i + skip < pht_log.size())
        chk({tag, "_pht"}, pht_log[i+skip], exp_pht[i]);
    for (int i = 0; i < exp_ghr.size(); i++)
      if (i < ghr_log.size())
        chk({tag, "_ghr"}, ghr_log[i], exp_ghr[i]);
    clear_all();
  endtask

  task automatic drain_compare(input string tag, input int skip);
    table_ready = 1'b1;
    repeat (12) tick();
    compare(tag, skip);
  endtask

  function automatic Update_Branch_S rand_upd();
    Update_Branch_S u;
    u.PC_Vaild        = 1'($urandom_range(0, 1));
    u.PC_Taken        = 1'($urandom_range(0, 1));
    u.PC_MissPredict  = 1'($urandom_range(0, 1));
    u.Update_PC       = $urandom;
    u.Update_Location = 1'($urandom_range(0, 1));
    u.Update_Target   = $urandom;
    u.BranchType      = BranchType_E'($urandom_range(0, 3));
    u.TBT_Counter     = 2'($urandom_range(0, 3));
    u.GHR             = 8'($urandom);
    u.Recover_GHR     = 8'($urandom);
    return u;
  endfunction

  initial begin
    Update_Branch_S u;
    int cycles;
    int bad;
    int len;

    // reset values
    repeat (3) tick();
    chk("rst_btb_we", btb_we, 0);
    chk("rst_pht_we", pht_we, 0);
    chk("rst_btb_idx", btb_idx, 0);
    chk("rst_pht_idx", pht_idx, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_overflow", upd_overflow, 0);
    chk("rst_ghr_valid", ghr_recover_valid, 0);
    chk("rst_ghr", ghr_recover, 0);

    // table clear sweep
    reset = 1'b0;
    table_ready = 1'b1;
    cycles = 0;
    while (!init_done && cycles < 2000) begin
      tick();
      cycles++;
    end
    chk("init_cycles", cycles, 2 * ROWS);
    chk("init_btb_cnt", btb_log.size(), 2 * ROWS);
    chk("init_pht_cnt", pht_log.size(), 2 * ROWS);
    bad = 0;
    foreach (btb_log[i])
      if (btb_log[i] !== 128'({8'(i >> 1), 1'(i & 1), 56'b0})) bad++;
    chk("init_btb_bad", bad, 0);
    bad = 0;
    foreach (pht_log[i])
      if (pht_log[i][1:0] !== 2'b01) bad++;
    chk("init_pht_bad", bad, 0);
    clear_all();

    // taken, counter saturates, minimum latency
    u = '0;
    u.PC_Vaild = 1'b1;
    u.PC_Taken = 1'b1;
    u.Update_PC = 32'h1000_0010;
    u.TBT_Counter = 2'd3;
    model(u, 1'b1);
    send(u);
    chk("lat_n1_pht_we", pht_we, 0);
    tick();
    chk("taken_pht_we", pht_we, 1);
    chk("taken_pht_idx", pht_idx, 8'h02);
    chk("taken_pht_wdata", pht_wdata, 2'd3);
    chk("taken_btb_we", btb_we, 0);
    drain_compare("taken", 0);

    // mispredicted not-taken
    u = '0;
    u.PC_Vaild = 1'b1;
    u.PC_MissPredict = 1'b1;
    u.Update_PC = 32'h1000_0100;
    u.Update_Target = 32'h2000_0040;
    u.Recover_GHR = 8'hA5;
    model(u, 1'b1);
    send(u);
    chk("misp_ghr_valid", ghr_recover_valid, 1);
    chk("misp_ghr", ghr_recover, 8'h4A);
    tick();
    chk("misp_pht_wdata", pht_wdata, 2'd0);
    chk("misp_btb_we", btb_we, 1);
    chk("misp_btb_target", btb_wdata.target, 32'h2000_0040);
    drain_compare("misp", 0);

    // false-hit invalidate
    u = '0;
    u.PC_MissPredict = 1'b1;
    u.Update_Location = 1'b1;
    u.Update_PC = 32'h0000_3458;
    u.Recover_GHR = 8'h3C;
    model(u, 1'b1);
    send(u);
    chk("inv_ghr", ghr_recover, 8'h3C);
    tick();
    chk("inv_btb_we", btb_we, 1);
    chk("inv_btb_slot", btb_slot, 1);
    chk("inv_btb_wdata", btb_wdata, 0);
    chk("inv_pht_we", pht_we, 0);
    drain_compare("inv", 0);

    // overflow under stall
    table_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      u = rand_upd();
      u.PC_Vaild = 1'b1;
      model(u, i < DEPTH);
      send(u);
    end
    chk("ovf_flag", upd_overflow, 1);
    chk("ovf_held_we", pht_we, 1);
    chk("ovf_held_pht", 128'({pht_idx, pht_wdata}), exp_pht[0]);
    drain_compare("ovf", 0);

    // random bursts with random write-port stalls
    for (int b = 0; b < 20; b++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) begin
        table_ready = 1'($urandom_range(0, 1));
        u = rand_upd();
        model(u, 1'b1);
        send(u);
      end
      drain_compare("rand", 0);
    end

    // reset while writing, then updates queued during the sweep
    table_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u = rand_upd();
      u.PC_Vaild = 1'b1;
      send(u);
    end
    reset = 1'b1;
    repeat (2) tick();
    clear_all();
    reset = 1'b0;
    chk("rst2_overflow", upd_overflow, 0);
    chk("rst2_init_done", init_done, 0);
    table_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u = rand_upd();
      u.PC_Vaild = 1'b1;
      model(u, 1'b1);
      send(u);
    end
    cycles = 0;
    while (!init_done && cycles < 2000) begin
      tick();
      cycles++;
    end
    chk("initq_done", init_done, 1);
    chk("initq_pre_pht", pht_log.size(), 2 * ROWS);
    drain_compare("initq", 2 * ROWS);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
